// File: rtl/tile_processor.sv
// Per-(triangle, tile) rasterizer setup. Computes the edge deltas and edge values at the tile origin,
// the z gradients (from two 32-step dividers) and z at the origin. Fixed 35-cycle latency.
module tile_processor #(
  parameter int FX_TOTAL_BITS     = 16,
  parameter int FX_FRAC_BITS      = 4,
  parameter int COLOR_BITS        = 8,
  parameter int TILE_COLUMNS_BITS = 5,
  parameter int TILE_ROWS_BITS    = 5,
  parameter int TILE_WIDTH_BITS   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            vld_in,
  output logic                            rdy_in,
  input  logic signed [FX_TOTAL_BITS-1:0] v0_x,
  input  logic signed [FX_TOTAL_BITS-1:0] v0_y,
  input  logic signed [FX_TOTAL_BITS-1:0] v0_z,
  input  logic signed [FX_TOTAL_BITS-1:0] v1_x,
  input  logic signed [FX_TOTAL_BITS-1:0] v1_y,
  input  logic signed [FX_TOTAL_BITS-1:0] v1_z,
  input  logic signed [FX_TOTAL_BITS-1:0] v2_x,
  input  logic signed [FX_TOTAL_BITS-1:0] v2_y,
  input  logic signed [FX_TOTAL_BITS-1:0] v2_z,
  input  logic [COLOR_BITS-1:0]           in_color,
  input  logic [TILE_COLUMNS_BITS-1:0]    in_tile_x,
  input  logic [TILE_ROWS_BITS-1:0]       in_tile_y,
  output logic                            vld_out,
  input  logic                            rdy_out,
  output logic signed [FX_TOTAL_BITS-1:0] out_abs_pos_x,
  output logic signed [FX_TOTAL_BITS-1:0] out_abs_pos_y,
  output logic signed [FX_TOTAL_BITS-1:0] out_abs_pos_z,
  output logic signed [FX_TOTAL_BITS-1:0] out_delta_0_x,
  output logic signed [FX_TOTAL_BITS-1:0] out_delta_0_y,
  output logic signed [FX_TOTAL_BITS-1:0] out_delta_0_z,
  output logic signed [FX_TOTAL_BITS-1:0] out_delta_1_x,
  output logic signed [FX_TOTAL_BITS-1:0] out_delta_1_y,
  output logic signed [FX_TOTAL_BITS-1:0] out_delta_1_z,
  output logic signed [FX_TOTAL_BITS-1:0] out_delta_2_x,
  output logic signed [FX_TOTAL_BITS-1:0] out_delta_2_y,
  output logic signed [FX_TOTAL_BITS-1:0] out_delta_2_z,
  output logic signed [2*FX_TOTAL_BITS-1:0] out_edge_0,
  output logic signed [2*FX_TOTAL_BITS-1:0] out_edge_1,
  output logic signed [2*FX_TOTAL_BITS-1:0] out_edge_2,
  output logic [COLOR_BITS-1:0]           out_color,
  output logic [TILE_COLUMNS_BITS-1:0]    out_tile_x,
  output logic [TILE_ROWS_BITS-1:0]       out_tile_y,
  output logic signed [FX_TOTAL_BITS-1:0] out_dzdx,
  output logic signed [FX_TOTAL_BITS-1:0] out_dzdy,
  output logic signed [2*FX_TOTAL_BITS-1:0] out_z_current
);

  localparam int W      = FX_TOTAL_BITS;
  localparam int W2     = 2 * FX_TOTAL_BITS;
  localparam int F      = FX_FRAC_BITS;
  localparam int ORG_SH = TILE_WIDTH_BITS + FX_FRAC_BITS;
  localparam int CW     = $clog2(W2);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_COEFF, S_DIV, S_ZCALC, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic   cap_en, setup_en, coeff_en, div_en, zcalc_en;

  logic signed [W-1:0]       vx_q [3];
  logic signed [W-1:0]       vy_q [3];
  logic signed [W-1:0]       vz_q [3];
  logic [COLOR_BITS-1:0]     color_q;
  logic [TILE_COLUMNS_BITS-1:0] tile_x_q;
  logic [TILE_ROWS_BITS-1:0] tile_y_q;

  logic signed [W-1:0]  abs_x_q, abs_y_q, abs_x_d, abs_y_d;
  logic signed [W-1:0]  dx_q [3];
  logic signed [W-1:0]  dy_q [3];
  logic signed [W-1:0]  dz_q [3];
  logic signed [W-1:0]  dx_d [3];
  logic signed [W-1:0]  dy_d [3];
  logic signed [W-1:0]  dz_d [3];
  logic signed [W-1:0]  ex_w [3];
  logic signed [W-1:0]  ey_w [3];
  logic signed [W2-1:0] edge_q [3];
  logic signed [W2-1:0] edge_d [3];

  logic signed [W2-1:0] a_w, b_w, c_w, na_w, nb_w;
  logic [W2-1:0]        mag_na_w, mag_nb_w, mag_c_w;

  logic [W2-1:0] rem_a_q, rem_b_q, quo_a_q, quo_b_q, dvsr_q;
  logic          neg_a_q, neg_b_q, c_zero_q;
  logic [CW-1:0] cnt_q;

  logic signed [W-1:0]  dzdx_q, dzdy_q, dzdx_d, dzdy_d, px_w, py_w;
  logic signed [W2-1:0] z_q, z_d;

  // One restoring-division step: returns {remainder, quotient} after shifting in the next dividend bit.
  function automatic logic [2*W2-1:0] div_step(input logic [W2-1:0] rem,
                                                input logic [W2-1:0] quo,
                                                input logic [W2-1:0] dvsr);
    logic [W2:0] sh;
    logic        ge;
    sh = {rem, quo[W2-1]};
    ge = (sh >= {1'b0, dvsr});
    div_step = {(ge ? W2'(sh - {1'b0, dvsr}) : sh[W2-1:0]), quo[W2-2:0], ge};
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst_n) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (vld_in) state_d = S_SETUP;
      S_SETUP: state_d = S_COEFF;
      S_COEFF: state_d = S_DIV;
      S_DIV:   if (cnt_q == CW'(W2 - 1)) state_d = S_ZCALC;
      S_ZCALC: state_d = S_DONE;
      S_DONE:  if (rdy_out) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdy_in   = (state_q == S_IDLE) && !rst_n;
    vld_out  = (state_q == S_DONE);
    cap_en   = (state_q == S_IDLE) && vld_in;
    setup_en = (state_q == S_SETUP);
    coeff_en = (state_q == S_COEFF);
    div_en   = (state_q == S_DIV);
    zcalc_en = (state_q == S_ZCALC);
  end

  // ---------------- Setup datapath ----------------
  assign abs_x_d = W'(tile_x_q) << ORG_SH;
  assign abs_y_d = W'(tile_y_q) << ORG_SH;

  for (genvar g = 0; g < 3; g++) begin : g_edge
    localparam int N = (g + 1) % 3;
    assign dx_d[g]   = vx_q[N] - vx_q[g];
    assign dy_d[g]   = vy_q[N] - vy_q[g];
    assign dz_d[g]   = vz_q[N] - vz_q[g];
    assign ex_w[g]   = abs_x_d - vx_q[g];
    assign ey_w[g]   = abs_y_d - vy_q[g];
    assign edge_d[g] = W2'(ex_w[g]) * W2'(dy_d[g]) - W2'(ey_w[g]) * W2'(dx_d[g]);
  end

  // Plane coefficients from edges 0 and 2; the dividers work on magnitudes.
  assign a_w = W2'(dy_q[0]) * W2'(dz_q[2]) - W2'(dz_q[0]) * W2'(dy_q[2]);
  assign b_w = W2'(dz_q[0]) * W2'(dx_q[2]) - W2'(dx_q[0]) * W2'(dz_q[2]);
  assign c_w = W2'(dx_q[0]) * W2'(dy_q[2]) - W2'(dy_q[0]) * W2'(dx_q[2]);
  assign na_w     = a_w <<< (2 * F);
  assign nb_w     = b_w <<< (2 * F);
  assign mag_na_w = na_w[W2-1] ? -na_w : na_w;
  assign mag_nb_w = nb_w[W2-1] ? -nb_w : nb_w;
  assign mag_c_w  = c_w[W2-1]  ? -c_w  : c_w;

  // Gradient is the negated signed quotient, so a positive magnitude is negated only when signs agree.
  assign dzdx_d = c_zero_q ? '0 : W'((neg_a_q ? quo_a_q : -quo_a_q) >> F);
  assign dzdy_d = c_zero_q ? '0 : W'((neg_b_q ? quo_b_q : -quo_b_q) >> F);
  assign px_w   = vx_q[0] - abs_x_q;
  assign py_w   = vy_q[0] - abs_y_q;
  assign z_d    = (W2'(vz_q[0]) <<< F) - W2'(px_w) * W2'(dzdx_d) - W2'(py_w) * W2'(dzdy_d);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      vx_q     <= '{default: '0};
      vy_q     <= '{default: '0};
      vz_q     <= '{default: '0};
      color_q  <= '0;
      tile_x_q <= '0;
      tile_y_q <= '0;
      abs_x_q  <= '0;
      abs_y_q  <= '0;
      dx_q     <= '{default: '0};
      dy_q     <= '{default: '0};
      dz_q     <= '{default: '0};
      edge_q   <= '{default: '0};
      rem_a_q  <= '0;
      rem_b_q  <= '0;
      quo_a_q  <= '0;
      quo_b_q  <= '0;
      dvsr_q   <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      c_zero_q <= 1'b0;
      cnt_q    <= '0;
      dzdx_q   <= '0;
      dzdy_q   <= '0;
      z_q      <= '0;
    end else begin
      if (cap_en) begin
        vx_q     <= '{v0_x, v1_x, v2_x};
        vy_q     <= '{v0_y, v1_y, v2_y};
        vz_q     <= '{v0_z, v1_z, v2_z};
        color_q  <= in_color;
        tile_x_q <= in_tile_x;
        tile_y_q <= in_tile_y;
      end
      if (setup_en) begin
        abs_x_q <= abs_x_d;
        abs_y_q <= abs_y_d;
        dx_q    <= dx_d;
        dy_q    <= dy_d;
        dz_q    <= dz_d;
        edge_q  <= edge_d;
      end
      if (coeff_en) begin
        rem_a_q  <= '0;
        rem_b_q  <= '0;
        quo_a_q  <= mag_na_w;
        quo_b_q  <= mag_nb_w;
        dvsr_q   <= mag_c_w;
        neg_a_q  <= na_w[W2-1] ^ c_w[W2-1];
        neg_b_q  <= nb_w[W2-1] ^ c_w[W2-1];
        c_zero_q <= (c_w == '0);
        cnt_q    <= '0;
      end
      if (div_en) begin
        {rem_a_q, quo_a_q} <= div_step(rem_a_q, quo_a_q, dvsr_q);
        {rem_b_q, quo_b_q} <= div_step(rem_b_q, quo_b_q, dvsr_q);
        cnt_q <= cnt_q + 1'b1;
      end
      if (zcalc_en) begin
        dzdx_q <= dzdx_d;
        dzdy_q <= dzdy_d;
        z_q    <= z_d;
      end
    end
  end

  assign out_abs_pos_x = abs_x_q;
  assign out_abs_pos_y = abs_y_q;
  assign out_abs_pos_z = '0;
  assign out_delta_0_x = dx_q[0];
  assign out_delta_0_y = dy_q[0];
  assign out_delta_0_z = dz_q[0];
  assign out_delta_1_x = dx_q[1];
  assign out_delta_1_y = dy_q[1];
  assign out_delta_1_z = dz_q[1];
  assign out_delta_2_x = dx_q[2];
  assign out_delta_2_y = dy_q[2];
  assign out_delta_2_z = dz_q[2];
  assign out_edge_0    = edge_q[0];
  assign out_edge_1    = edge_q[1];
  assign out_edge_2    = edge_q[2];
  assign out_color     = color_q;
  assign out_tile_x    = tile_x_q;
  assign out_tile_y    = tile_y_q;
  assign out_dzdx      = dzdx_q;
  assign out_dzdy      = dzdy_q;
  assign out_z_current = z_q;

endmodule

// File: tb/tb_tile_processor.sv
// Directed bench for tile_processor: hand-computed triangles, handshake, degenerate and mid-reset cases.
module tb_tile_processor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, vld_in, rdy_in, vld_out, rdy_out;
  logic signed [15:0] v0_x, v0_y, v0_z, v1_x, v1_y, v1_z, v2_x, v2_y, v2_z;
  logic [7:0] in_color, out_color;
  logic [4:0] in_tile_x, in_tile_y, out_tile_x, out_tile_y;
  logic signed [15:0] out_abs_pos_x, out_abs_pos_y, out_abs_pos_z;
  logic signed [15:0] out_delta_0_x, out_delta_0_y, out_delta_0_z;
  logic signed [15:0] out_delta_1_x, out_delta_1_y, out_delta_1_z;
  logic signed [15:0] out_delta_2_x, out_delta_2_y, out_delta_2_z;
  logic signed [31:0] out_edge_0, out_edge_1, out_edge_2, out_z_current;
  logic signed [15:0] out_dzdx, out_dzdy;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  tile_processor dut (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .rdy_in(rdy_in),
    .v0_x(v0_x), .v0_y(v0_y), .v0_z(v0_z),
    .v1_x(v1_x), .v1_y(v1_y), .v1_z(v1_z),
    .v2_x(v2_x), .v2_y(v2_y), .v2_z(v2_z),
    .in_color(in_color), .in_tile_x(in_tile_x), .in_tile_y(in_tile_y),
    .vld_out(vld_out), .rdy_out(rdy_out),
    .out_abs_pos_x(out_abs_pos_x), .out_abs_pos_y(out_abs_pos_y), .out_abs_pos_z(out_abs_pos_z),
    .out_delta_0_x(out_delta_0_x), .out_delta_0_y(out_delta_0_y), .out_delta_0_z(out_delta_0_z),
    .out_delta_1_x(out_delta_1_x), .out_delta_1_y(out_delta_1_y), .out_delta_1_z(out_delta_1_z),
    .out_delta_2_x(out_delta_2_x), .out_delta_2_y(out_delta_2_y), .out_delta_2_z(out_delta_2_z),
    .out_edge_0(out_edge_0), .out_edge_1(out_edge_1), .out_edge_2(out_edge_2),
    .out_color(out_color), .out_tile_x(out_tile_x), .out_tile_y(out_tile_y),
    .out_dzdx(out_dzdx), .out_dzdy(out_dzdy), .out_z_current(out_z_current)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Vertices in integer pixel units; converted to 12.4 raw here.
  task automatic set_tri(input int x0, input int y0, input int z0,
                         input int x1, input int y1, input int z1,
                         input int x2, input int y2, input int z2,
                         input int col, input int tx, input int ty);
    v0_x = 16'(x0 * 16); v0_y = 16'(y0 * 16); v0_z = 16'(z0 * 16);
    v1_x = 16'(x1 * 16); v1_y = 16'(y1 * 16); v1_z = 16'(z1 * 16);
    v2_x = 16'(x2 * 16); v2_y = 16'(y2 * 16); v2_z = 16'(z2 * 16);
    in_color = 8'(col); in_tile_x = 5'(tx); in_tile_y = 5'(ty);
  endtask

  task automatic start_tri();
    int k;
    k = 0;
    while (!rdy_in && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("rdy_in_before_capture", rdy_in, 1);
    @(negedge clk); vld_in = 1'b1;
    @(posedge clk); #1; vld_in = 1'b0;
  endtask

  task automatic run_tri(output int latency);
    start_tri();
    latency = 0;
    while (!vld_out && latency < 100) begin
      @(posedge clk); #1; latency++;
    end
  endtask

  task automatic accept();
    @(negedge clk); rdy_out = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); rdy_out = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; vld_in = 1'b0; rdy_out = 1'b0;
    set_tri(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy_in", rdy_in, 0);
    check("rst_vld_out", vld_out, 0);
    check("rst_edge0", out_edge_0, 0);
    check("rst_z", out_z_current, 0);
    check("rst_color", out_color, 0);
    @(negedge clk); rst_n = 1'b0;
    #1 check("idle_rdy_in", rdy_in, 1);

    // Flat triangle
    set_tri(1, 14, 512, 12, 15, 512, 7, 2, 512, 1, 0, 0);
    run_tri(lat);
    check("flat_latency", lat, 35);
    check("flat_d0x", out_delta_0_x, 176);
    check("flat_d0y", out_delta_0_y, 16);
    check("flat_d0z", out_delta_0_z, 0);
    check("flat_d1x", out_delta_1_x, -80);
    check("flat_d1y", out_delta_1_y, -208);
    check("flat_d2x", out_delta_2_x, -96);
    check("flat_d2y", out_delta_2_y, 192);
    check("flat_edge0", out_edge_0, 39168);
    check("flat_edge1", out_edge_1, 20736);
    check("flat_edge2", out_edge_2, -24576);
    check("flat_dzdx", out_dzdx, 0);
    check("flat_dzdy", out_dzdy, 0);
    check("flat_z", out_z_current, 131072);
    check("flat_absx", out_abs_pos_x, 0);
    check("flat_absz", out_abs_pos_z, 0);
    check("flat_color", out_color, 1);

    // Backpressure: results hold, busy pulse on vld_in is ignored
    repeat (3) @(posedge clk);
    #1;
    check("hold_vld_out", vld_out, 1);
    check("hold_rdy_in", rdy_in, 0);
    @(negedge clk);
    set_tri(3, 3, 9, 5, 9, 9, 9, 4, 9, 9, 3, 3);
    vld_in = 1'b1;
    @(posedge clk); #1; vld_in = 1'b0;
    check("busy_vld_out", vld_out, 1);
    check("busy_color", out_color, 1);
    check("busy_edge0", out_edge_0, 39168);
    check("busy_z", out_z_current, 131072);
    @(negedge clk); rdy_out = 1'b1;
    @(posedge clk); #1;
    check("hs_vld_out_fall", vld_out, 0);
    check("hs_rdy_in_rise", rdy_in, 1);
    @(negedge clk); rdy_out = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hs_no_spurious", vld_out, 0);
    check("hs_still_idle", rdy_in, 1);

    // X-skewed
    set_tri(1, 1, 256, 1, 2, 256, 20, 1, 1024, 2, 0, 0);
    run_tri(lat);
    check("xs_latency", lat, 35);
    check("xs_dzdx", out_dzdx, 646);
    check("xs_dzdy", out_dzdy, 0);
    check("xs_z", out_z_current, 55200);
    check("xs_d0y", out_delta_0_y, 16);
    check("xs_d2x", out_delta_2_x, -304);
    check("xs_d2z", out_delta_2_z, -12288);
    check("xs_edge0", out_edge_0, -256);
    accept();

    // Y-skewed, tile 0 then tile 2
    set_tri(1, 1, 256, 1, 20, 1024, 2, 1, 256, 3, 0, 0);
    run_tri(lat);
    check("ys_dzdx", out_dzdx, 0);
    check("ys_dzdy", out_dzdy, 646);
    check("ys_z", out_z_current, 55200);
    accept();
    set_tri(1, 1, 256, 1, 20, 1024, 2, 1, 256, 4, 2, 0);
    run_tri(lat);
    check("yt2_latency", lat, 35);
    check("yt2_absx", out_abs_pos_x, 512);
    check("yt2_absy", out_abs_pos_y, 0);
    check("yt2_tilex", out_tile_x, 2);
    check("yt2_color", out_color, 4);
    check("yt2_z", out_z_current, 55200);
    check("yt2_dzdy", out_dzdy, 646);
    check("yt2_edge0", out_edge_0, 150784);
    check("yt2_edge1", out_edge_1, -145664);
    check("yt2_edge2", out_edge_2, -256);
    accept();

    // Degenerate (collinear, C == 0), tile (1,1)
    set_tri(1, 1, 100, 2, 2, 200, 3, 3, 300, 5, 1, 1);
    run_tri(lat);
    check("deg_latency", lat, 35);
    check("deg_dzdx", out_dzdx, 0);
    check("deg_dzdy", out_dzdy, 0);
    check("deg_z", out_z_current, 25600);
    check("deg_absy", out_abs_pos_y, 256);
    accept();

    // Reset while dividing
    set_tri(1, 1, 256, 1, 2, 256, 20, 1, 1024, 7, 1, 1);
    start_tri();
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy", rdy_in, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_vld_out", vld_out, 0);
    check("mid_rst_rdy_in", rdy_in, 0);
    check("mid_rst_edge0", out_edge_0, 0);
    check("mid_rst_d2x", out_delta_2_x, 0);
    check("mid_rst_color", out_color, 0);
    check("mid_rst_tilex", out_tile_x, 0);
    check("mid_rst_absx", out_abs_pos_x, 0);
    check("mid_rst_z", out_z_current, 0);
    @(negedge clk); rst_n = 1'b0;
    #1 check("post_rst_rdy_in", rdy_in, 1);
    set_tri(1, 1, 256, 1, 20, 1024, 2, 1, 256, 4, 2, 0);
    run_tri(lat);
    check("post_rst_latency", lat, 35);
    check("post_rst_z", out_z_current, 55200);
    check("post_rst_dzdy", out_dzdy, 646);
    accept();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_processor.md
Name: tile_processor

Overview:
Per-(triangle, tile) setup stage of the rasterizer. Takes three 12.4 fixed-point screen-space vertices plus colour and tile coordinates. Produces the tile's absolute origin, edge deltas, edge-function values at the origin, the z gradients dz/dx and dz/dy, and z at the origin for the downstream pixel-traversal stage. Uses a valid/ready handshake on both sides; the divider is multi-cycle.

Parameters:
FX_TOTAL_BITS, 16, fixed-point word width (signed).
FX_FRAC_BITS, 4, fractional bits (12.4 format); FX_INT_BITS = FX_TOTAL_BITS - FX_FRAC_BITS.
COLOR_BITS, 8, colour width.
TILE_COLUMNS_BITS, 5, tile column index width.
TILE_ROWS_BITS, 5, tile row index width.
TILE_WIDTH_BITS, 4, log2 of tile edge in pixels.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous reset, active-high (1 = reset).
vld_in  in  1  input triangle valid.
rdy_in  out  1  block can accept a triangle.
v0_x/v0_y/v0_z, v1_*, v2_*  in  FX_TOTAL_BITS each  signed 12.4 vertices.
in_color  in  COLOR_BITS  triangle colour.
in_tile_x  in  TILE_COLUMNS_BITS  tile column index.
in_tile_y  in  TILE_ROWS_BITS  tile row index.
vld_out  out  1  results valid.
rdy_out  in  1  downstream accepts results.
out_abs_pos_x/y/z  out  FX_TOTAL_BITS  tile origin, 12.4.
out_delta_{0,1,2}_{x,y,z}  out  FX_TOTAL_BITS  edge deltas, 12.4.
out_edge_0/1/2  out  2*FX_TOTAL_BITS  edge values, 24.8.
out_color, out_tile_x, out_tile_y  out  as inputs  registered pass-through.
out_dzdx, out_dzdy  out  FX_TOTAL_BITS  z gradients, 12.4.
out_z_current  out  2*FX_TOTAL_BITS  z at tile origin, 24.8.

Behaviour:
- Reset: all outputs 0, vld_out=0, rdy_in=0 while reset is held; state IDLE. Reset mid-operation discards the current triangle.
- FSM states: IDLE (rdy_in=1) -> SETUP -> COEFF -> DIV (32 cycles) -> ZCALC -> DONE (vld_out=1) -> IDLE.
- IDLE: on a rising edge with vld_in=1, register all inputs and go to SETUP. rdy_in stays 0 from that edge until the DONE handshake completes. vld_in is ignored outside IDLE.
- vld_out rises on the 35th rising edge after capture, fixed latency including the C=0 case. Outputs hold stable while vld_out=1.
- Result handshake: on a rising edge with vld_out=1 and rdy_out=1, vld_out falls and the block returns to IDLE (rdy_in=1).
- Origin: abs.x = tile_x << (TILE_WIDTH_BITS+FX_FRAC_BITS); abs.y is the same using tile_y; abs.z = 0.
- Deltas: d_i = v_((i+1) mod 3) - v_i per component, FX_TOTAL_BITS, two's-complement wrap.
- Edges: edge_i = (abs.x - v_i.x)*d_i.y - (abs.y - v_i.y)*d_i.x. Subtractions are 16-bit wrap; products are signed 16x16 -> 32; the final subtract wraps at 32 bits.
- Plane coefficients (32-bit signed):
  A = d0.y*d2.z - d0.z*d2.y
  B = d0.z*d2.x - d0.x*d2.z
  C = d0.x*d2.y - d0.y*d2.x
- Gradients:
  qx = -((A << 2*FX_FRAC_BITS) / C); the shift is truncated to 32 bits; signed division truncates toward zero.
  qy uses B in place of A, same rules.
  out_dzdx = qx[FX_TOTAL_BITS-1+FX_FRAC_BITS : FX_FRAC_BITS]; out_dzdy is taken from qy the same way.
  If C == 0, dzdx = dzdy = 0.
- z_current = sext32(v0.z << FX_FRAC_BITS) - (v0.x - abs.x)*dzdx - (v0.y - abs.y)*dzdy. Signed products, 32-bit wrap.
- DIV: two parallel signed restoring/non-restoring dividers, 32 iterations.

Test Plan:
- Flat triangle: v0=(1,14,512), v1=(12,15,512), v2=(7,2,512) integer units (raw = value<<4), tile (0,0), colour 1 -> required outputs:
  deltas d0=(176,16,0), d1=(-80,-208,0), d2=(-96,192,0) raw;
  edges 39168, 20736, -24576;
  dzdx=dzdy=0, z_current=131072, abs_pos=0, colour 1.
- X-skewed triangle: (1,1,256), (1,2,256), (20,1,1024), tile (0,0) -> dzdx=646 raw, dzdy=0, z_current=55200, d0=(0,16,0), d2=(-304,0,-12288).
- Y-skewed triangle: (1,1,256), (1,20,1024), (2,1,256) -> dzdx=0, dzdy=646, z_current=55200. Same vertices with tile_x=2, colour 4 -> abs_pos_x=512, out_tile_x=2, z_current=55200.
- Handshake: hold rdy_out=0 -> vld_out stays 1 and outputs stay stable, rdy_in=0. Pulse vld_in while busy -> ignored. Raise rdy_out -> vld_out falls next edge, rdy_in returns to 1.
- Degenerate triangle: collinear vertices (C=0) -> dzdx=dzdy=0, vld_out still rises 35 cycles after capture.
- Reset asserted during DIV -> next edge vld_out=0 and all outputs 0. After release the block is IDLE with rdy_in=1 and accepts a new triangle.
